// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end: fetch FSM state
// encoding, the NOP bubble word and PC stepping constants.
package arm_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at the current PC
    DROP  = 2'd1,  // squashed request in flight; its data will be thrown away
    FULL  = 2'd2   // one fetched instruction parked while decode is stalled
  } fetch_state_e;

  // MOV R0,R0 -- architecturally a no-op, used to fill IF/ID on a bubble.
  localparam logic [31:0] BUBBLE_INSTR = 32'hE1A0_0000;

  // Byte distance between consecutive ARM instructions.
  localparam logic [31:0] PC_INC = 32'd4;

  // Clears the byte-offset bits of an address so it points at a whole word.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} pair that arrived
// while decode was stalled. Load takes priority over clear.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Occupancy flag: set on load, cleared on drain/discard or reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload capture.
  // NOTE: the data registers are deliberately not reset; valid_q alone
  // says whether they mean anything, and a reset-free datapath is cheaper.
  always_ff @(posedge clk) begin
    if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to
// instruction memory, loads IF/ID, honours decode stalls and EX redirects,
// and discards responses to requests that a branch has squashed.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = arm_pkg::BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] pc_out
);

  import arm_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [29:0]  drop_addr_q, drop_addr_d;   // address of the squashed request

  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;

  logic         req_c;
  logic [29:0]  addr_c;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;

  // Candidate instruction for IF/ID this cycle (from memory or skid buffer).
  logic         new_valid;
  logic [31:0]  new_instr, new_pc;

  logic [31:0]  pc_plus4;
  logic [31:0]  br_pc;

  assign pc_plus4 = pc_q + PC_INC;          // wraps modulo 2^32
  assign br_pc    = br_target & WORD_MASK;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_plus4),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // Next-state, PC and memory-port decode for the fetch FSM.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    req_c       = 1'b0;
    addr_c      = pc_q[31:2];
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    new_valid   = 1'b0;
    new_instr   = imem_rdata;
    new_pc      = pc_plus4;

    unique case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (br_taken) begin
          pc_d = br_pc;
          // Same-cycle ack retires the old request; otherwise wait it out.
          if (!imem_ack) begin
            state_d     = DROP;
            drop_addr_d = pc_q[31:2];
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (id_stall) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else begin
            new_valid = 1'b1;
          end
        end
      end

      DROP: begin
        // Keep presenting the squashed address until memory acknowledges it.
        req_c  = 1'b1;
        addr_c = drop_addr_q;
        if (br_taken) begin
          pc_d = br_pc;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end

      FULL: begin
        if (br_taken) begin
          pc_d       = br_pc;
          skid_clear = 1'b1;
          state_d    = FETCH;
        end else if (!id_stall) begin
          new_valid  = skid_valid;
          new_instr  = skid_instr;
          new_pc     = skid_pc;
          skid_clear = 1'b1;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // IF/ID update: branch squash, then stall hold, then load, else bubble.
  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if (br_taken) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = BUBBLE_INSTR;
      if_id_pc_d    = 32'd0;
    end else if (id_stall) begin
      // hold
    end else if (new_valid) begin
      if_id_valid_d = 1'b1;
      if_id_instr_d = new_instr;
      if_id_pc_d    = new_pc;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = BUBBLE_INSTR;
      if_id_pc_d    = 32'd0;
    end
  end

  // FSM, PC and IF/ID registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      drop_addr_q   <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= BUBBLE_INSTR;
      if_id_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  assign imem_req    = req_c & ~rst;
  assign imem_addr   = addr_c;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the zero-wait stream,
// stall and branch cases, plus hand-written sequences for wait-state
// branches, PC wrap and reset during an outstanding request.
module tb_fetch_ctrl;

  localparam logic [31:0] BUB = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_stall, br_taken;
  logic [31:0] br_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, pc_out;

  // Second instance exercising PC wrap with a zero-wait memory.
  logic        w_req;
  logic [29:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_pc_out;

  // Memory model: ack after mem_wait wait cycles; data = word index.
  int   mem_wait;
  int   wait_cnt;
  logic ack_force;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_force | (imem_req && (wait_cnt == mem_wait));
  assign imem_rdata = ack_force ? 32'hDEAD_BEEF : {2'b00, imem_addr};

  always @(posedge clk) begin
    if (rst || imem_ack) wait_cnt <= 0;
    else if (imem_req)   wait_cnt <= wait_cnt + 1;
  end

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .pc_out(pc_out)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata({2'b00, w_addr}),
    .id_stall(1'b0), .br_taken(1'b0), .br_target(32'h0),
    .if_id_valid(w_valid), .if_id_instr(w_instr),
    .if_id_pc(w_pc), .pc_out(w_pc_out)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [29:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, advance one clock, return 1ns after the edge.
  task automatic step(input logic stall, input logic br, input logic [31:0] tgt);
    id_stall  = stall;
    br_taken  = br;
    br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_if_id(input string tag, input logic v,
                             input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc"}, if_id_pc, pc);
  endtask

  task automatic do_reset(input int wait_cycles);
    rst = 1'b1; ack_force = 1'b0; mem_wait = wait_cycles;
    id_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_if_id("rst", 1'b0, BUB, 32'h0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.pc_out", pc_out, 32'h0);
    rst = 1'b0;
    #1;
    check("rst.first_req", {31'd0, imem_req}, 32'd1);
    check("rst.first_addr", {2'b00, imem_addr}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;

    //          stall br  target      valid instr      pc          req addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,     32'h4,      1'b1, 30'h1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1,     32'h8,      1'b1, 30'h2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1,     32'h8,      1'b0, 30'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1,     32'h8,      1'b0, 30'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1,     32'h8,      1'b0, 30'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2,     32'hC,      1'b1, 30'h3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h3,     32'h10,     1'b1, 30'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,     32'h14,     1'b1, 30'h5};
    vecs[8]  = '{1'b1, 1'b1, 32'h100, 1'b0, BUB,       32'h0,      1'b1, 30'h40};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,    32'h104,    1'b1, 30'h41};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h40,    32'h104,    1'b0, 30'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h203, 1'b0, BUB,       32'h0,      1'b1, 30'h80};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h80,    32'h204,    1'b1, 30'h81};

    // Zero-wait stream, stall, branch+stall (from FETCH and from FULL).
    do_reset(0);
    check("wrap.rst_pc_out", w_pc_out, 32'hFFFF_FFFC);
    check("wrap.first_addr", {2'b00, w_addr}, 32'h3FFF_FFFF);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      check_if_id($sformatf("v%0d", i), vecs[i].exp_valid,
                  vecs[i].exp_instr, vecs[i].exp_pc);
      check($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("v%0d.addr", i), {2'b00, imem_addr}, {2'b00, vecs[i].exp_addr});
      if (i == 0) begin
        check("wrap.valid", {31'd0, w_valid}, 32'd1);
        check("wrap.instr", w_instr, 32'h3FFF_FFFF);
        check("wrap.if_id_pc", w_pc, 32'h0);
        check("wrap.second_addr", {2'b00, w_addr}, 32'h0);
      end
    end

    // Branch while the wait-state request for 0x10 is outstanding.
    do_reset(1);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (imem_req && imem_addr == 30'h4) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0);
    end
    check("ws.reached_0x10", {31'd0, found}, 32'd1);
    step(1'b0, 1'b1, 32'h40);
    check("ws.br.valid", {31'd0, if_id_valid}, 32'd0);
    check("ws.drop.addr_held", {2'b00, imem_addr}, 32'h4);
    check("ws.drop.req", {31'd0, imem_req}, 32'd1);
    check("ws.pc_out", pc_out, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    check("ws.discard.valid", {31'd0, if_id_valid}, 32'd0);
    check("ws.redirect.addr", {2'b00, imem_addr}, 32'h10);
    step(1'b0, 1'b0, 32'h0);
    check("ws.wait.valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check_if_id("ws.target", 1'b1, 32'h10, 32'h44);

    // Reset while DROP waits on ack; a stale ack during reset is ignored.
    do_reset(1);
    step(1'b0, 1'b1, 32'h80);
    check("mr.drop.addr", {2'b00, imem_addr}, 32'h0);
    check("mr.drop.pc_out", pc_out, 32'h80);
    br_taken  = 1'b0;
    rst       = 1'b1;
    ack_force = 1'b1;
    #1;
    check("mr.req_in_rst", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ack_force = 1'b0;
    #1;
    check_if_id("mr.after_rst", 1'b0, BUB, 32'h0);
    check("mr.pc_out", pc_out, 32'h0);
    check("mr.req", {31'd0, imem_req}, 32'd1);
    check("mr.addr", {2'b00, imem_addr}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("mr.wait.valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check_if_id("mr.first", 1'b1, 32'h0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
